// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and helpers for the bit-serial subtractor.
//            - state_e   : control FSM encoding
//            - cnt_width : bit-counter width for an N-bit operation
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter has to hold 0..N-1 without wrapping early. $clog2(2) is 1, but
  // the floor of 1 also protects against degenerate parameter values.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/done operand and result bundle of the serial subtractor.
// Signals  : start, a[N], b[N], bin        - request side (master drives)
//            busy, done, diff[N], bout,
//            zero, ovf                     - status/result side (slave drives)
// Modports : master (requester), slave (subtractor)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int N = 8
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : Combinational 1-bit subtractor cell, d = x - y - bi.
// Ports    : x  (in)  minuend bit
//            y  (in)  subtrahend bit
//            bi (in)  borrow in
//            d  (out) difference bit
//            bo (out) borrow out
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic xy_diff;

  assign xy_diff = x ^ y;
  assign d       = xy_diff ^ bi;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bo      = (~x & y) | (~xy_diff & bi);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial N-bit subtractor, {bout, diff} = a - b - bin,
//            one bit per clock, LSB first, with start/done handshake.
// Ports    : clk   (in)  rising-edge clock
//            rst_n (in)  asynchronous active-low reset
//            bus   (slave modport of serial_subtractor_if)
//              start/a/b/bin in, busy/done/diff/bout/zero/ovf out
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q;
  logic [N-1:0]  a_sh_q;
  logic [N-1:0]  b_sh_q;
  logic [N-1:0]  w_q;
  logic          br_q;
  logic          a_msb_q;
  logic          b_msb_q;
  logic [CW-1:0] cnt_q;

  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          zero_q;
  logic          ovf_q;

  logic          fs_d;
  logic          fs_bo;
  logic [N-1:0]  w_d;
  logic          start_acc;

  // One shared cell; the shift registers present a new bit pair each cycle.
  full_subtractor u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Difference bits enter at the MSB, so after N shifts bit 0 sits at w[0].
  assign w_d       = {fs_d, w_q[N-1:1]};
  // DONE accepts a new request too, which gives N+1 cycle throughput.
  assign start_acc = bus.start && (state_q != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      w_q     <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          w_q    <= w_d;
          br_q   <= fs_bo;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          diff_q  <= w_q;
          bout_q  <= br_q;
          zero_q  <= (w_q == '0);
          // Signed overflow only possible when operand signs differ.
          ovf_q   <= (a_msb_q != b_msb_q) && (w_q[N-1] != a_msb_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Placed after the case so an accept in DONE overrides the IDLE return.
      if (start_acc) begin
        a_sh_q  <= bus.a;
        b_sh_q  <= bus.b;
        br_q    <= bus.bin;
        a_msb_q <= bus.a[N-1];
        b_msb_q <= bus.b[N-1];
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor, N=8 and N=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_subtractor_if #(.N(8)) m8 ();
  serial_subtractor_if #(.N(4)) m4 ();

  serial_subtractor #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m8.slave)
  );

  serial_subtractor #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the N=8 instance and wait for its done pulse.
  // lat counts rising edges after the accepting edge until done is seen.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic z,
                        output logic ov, output int lat);
    @(negedge clk);
    m8.a = a; m8.b = b; m8.bin = bin; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    lat = 0;
    while (m8.done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    d = m8.diff; bo = m8.bout; z = m8.zero; ov = m8.ovf;
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output logic [3:0] d, output logic bo, output logic z,
                        output logic ov, output int lat);
    @(negedge clk);
    m4.a = a; m4.b = b; m4.bin = bin; m4.start = 1'b1;
    @(posedge clk); #1;
    m4.start = 1'b0;
    lat = 0;
    while (m4.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = m4.diff; bo = m4.bout; z = m4.zero; ov = m4.ovf;
  endtask

  task automatic test_reset();
    logic [12:0] got8;
    logic [8:0]  got4;
    got8 = {m8.busy, m8.done, m8.diff, m8.bout, m8.zero, m8.ovf};
    n_tests++;
    if (got8 !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8 {busy,done,diff,bout,zero,ovf} got %b want 0000000000010", got8);
    end
    got4 = {m4.busy, m4.done, m4.diff, m4.bout, m4.zero, m4.ovf};
    n_tests++;
    if (got4 !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset4 {busy,done,diff,bout,zero,ovf} got %b want 000000010", got4);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       bo, z, ov;
    int         lat;

    do_op8(8'd5, 8'd3, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL latency_5m3 got %0d want 9", lat);
    end
    n_tests++;
    if ({d, bo, z, ov} !== {8'd2, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_5m3 diff=%0d bout=%b zero=%b ovf=%b want 2 0 0 0", d, bo, z, ov);
    end

    do_op8(8'd3, 8'd5, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if ({d, bo, z, ov} !== {8'd254, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_3m5 diff=%0d bout=%b zero=%b ovf=%b want 254 1 0 0", d, bo, z, ov);
    end

    do_op8(8'd0, 8'd0, 1'b1, d, bo, z, ov, lat);
    n_tests++;
    if ({d, bo, z, ov} !== {8'd255, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_0m0b1 diff=%0d bout=%b zero=%b ovf=%b want 255 1 0 0", d, bo, z, ov);
    end

    do_op8(8'd7, 8'd7, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if ({d, bo, z, ov} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_7m7 diff=%0d bout=%b zero=%b ovf=%b want 0 0 1 0", d, bo, z, ov);
    end

    do_op8(8'd128, 8'd1, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if ({d, bo, z, ov} !== {8'd127, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL sub_128m1 diff=%0d bout=%b zero=%b ovf=%b want 127 0 0 1", d, bo, z, ov);
    end
  endtask

  // Starts raised mid-run must not disturb the operation in flight, and the
  // previous result (127) must stay put until the new one lands.
  task automatic test_ignore_busy();
    int lat;
    int extra_done;
    logic busy_ok;
    logic diff_stable;

    busy_ok     = 1'b1;
    diff_stable = 1'b1;
    @(negedge clk);
    m8.a = 8'd50; m8.b = 8'd8; m8.bin = 1'b0; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    lat = 0;
    while (m8.done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      if (lat == 2 || lat == 3) begin
        m8.a = 8'd1; m8.b = 8'd2; m8.bin = 1'b1; m8.start = 1'b1;
      end else begin
        m8.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat < 8 && m8.busy !== 1'b1) busy_ok = 1'b0;
      if (lat < 9 && m8.diff !== 8'd127) diff_stable = 1'b0;
    end
    m8.start = 1'b0;

    n_tests++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL ignore_latency got %0d want 9", lat);
    end
    n_tests++;
    if ({m8.diff, m8.bout, m8.ovf} !== {8'd42, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ignore_result diff=%0d bout=%b ovf=%b want 42 0 0", m8.diff, m8.bout, m8.ovf);
    end
    n_tests++;
    if (busy_ok !== 1'b1) begin
      n_fail++; $display("FAIL busy_in_run got %b want 1", busy_ok);
    end
    n_tests++;
    if (diff_stable !== 1'b1) begin
      n_fail++; $display("FAIL diff_stable_in_run got %b want 1", diff_stable);
    end

    extra_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (m8.done === 1'b1) extra_done++;
    end
    n_tests++;
    if (extra_done !== 0) begin
      n_fail++; $display("FAIL ignore_no_extra_done got %0d want 0", extra_done);
    end
  endtask

  // start held high with new operands every cycle: accepts at edges 0, 9, 18,
  // done seen after edges 9, 18, 27. Operands at edge i: a=10i+3, b=3i, bin=i%2.
  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    int         n_done;
    int         bad;

    exp_d[0] = 8'd3;    // 3 - 0 - 0
    exp_d[1] = 8'd65;   // 93 - 27 - 1
    exp_d[2] = 8'd129;  // 183 - 54 - 0
    n_done = 0;
    bad    = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      m8.a = 8'(10 * i + 3); m8.b = 8'(3 * i); m8.bin = i[0]; m8.start = 1'b1;
      @(posedge clk); #1;
      if (m8.done === 1'b1) begin
        if (n_done < 3) begin
          n_tests++;
          if (i !== 9 * (n_done + 1) || m8.diff !== exp_d[n_done]) begin
            n_fail++;
            $display("FAIL b2b_result%0d edge=%0d diff=%0d want edge=%0d diff=%0d",
                     n_done, i, m8.diff, 9 * (n_done + 1), exp_d[n_done]);
          end
        end else begin
          bad++;
        end
        n_done++;
      end
    end
    @(negedge clk);
    m8.start = 1'b0;
    n_tests++;
    if (n_done !== 3 || bad !== 0) begin
      n_fail++; $display("FAIL b2b_done_count got %0d want 3", n_done);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0]  d;
    logic        bo, z, ov;
    int          lat;
    int          n_done;
    logic [12:0] got;

    do_op8(8'd9, 8'd1, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if (d !== 8'd8) begin
      n_fail++; $display("FAIL pre_reset_op diff=%0d want 8", d);
    end

    @(negedge clk);
    m8.a = 8'd200; m8.b = 8'd100; m8.bin = 1'b0; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {m8.busy, m8.done, m8.diff, m8.bout, m8.zero, m8.ovf};
    n_tests++;
    if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_outputs got %b want 0000000000010", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (m8.done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done got %0d want 0", n_done);
    end

    do_op8(8'd10, 8'd4, 1'b0, d, bo, z, ov, lat);
    n_tests++;
    if ({d, bo, z, ov, lat[7:0]} !== {8'd6, 1'b0, 1'b0, 1'b0, 8'd9}) begin
      n_fail++; $display("FAIL post_reset_10m4 diff=%0d bout=%b zero=%b lat=%0d want 6 0 0 9", d, bo, z, lat);
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] d;
    logic       bo, z, ov;
    int         lat;
    logic [4:0] exp_v;
    logic       exp_ovf;
    logic       exp_zero;
    logic [3:0] av, bv;

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          av = 4'(ai);
          bv = 4'(bi);
          do_op4(av, bv, ci[0], d, bo, z, ov, lat);
          exp_v    = {1'b0, av} - {1'b0, bv} - {4'b0, ci[0]};
          exp_zero = (exp_v[3:0] == 4'h0);
          exp_ovf  = (av[3] != bv[3]) && (exp_v[3] != av[3]);
          n_tests++;
          if ({bo, d, z, ov} !== {exp_v, exp_zero, exp_ovf} || lat !== 5) begin
            n_fail++;
            $display("FAIL n4 a=%0d b=%0d bin=%0d got bout=%b diff=%0d zero=%b ovf=%b lat=%0d want %b %0d %b %b 5",
                     av, bv, ci, bo, d, z, ov, lat, exp_v[4], exp_v[3:0], exp_zero, exp_ovf);
          end
        end
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.bin = 1'b0;
    m4.start = 1'b0; m4.a = '0; m4.b = '0; m4.bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;

    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
